// File: rtl/rst_run_sequencer_if.sv
// Control/status bundle between the reset sequencer and whoever
// supervises core bring-up (board logic or a bench).
interface rst_run_sequencer_if #(
    parameter int N_CHAN    = 2,
    parameter int CNT_WIDTH = 16
);
    logic                 i_restart;
    logic [N_CHAN-1:0]    o_rst;
    logic                 o_running;
    logic                 o_done;
    logic [CNT_WIDTH-1:0] o_cycle;

    modport master (
        output i_restart,
        input  o_rst, o_running, o_done, o_cycle
    );

    modport slave (
        input  i_restart,
        output o_rst, o_running, o_done, o_cycle
    );
endinterface

// File: rtl/rst_run_sequencer.sv
// Staggered per-core reset release followed by a bounded run window;
// cores are parked back in reset when the window expires.
module rst_run_sequencer #(
    parameter int N_CHAN      = 2,
    parameter int HOLD_CYCLES = 5,
    parameter int STAGGER     = 4,
    parameter int RUN_CYCLES  = 58,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rst_run_sequencer_if.slave   bus
);
    localparam int CHW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam bit ALL_AT_ONCE = (N_CHAN == 1) || (STAGGER == 0);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STAG_LAST = CNT_WIDTH'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] RUN_LAST  = CNT_WIDTH'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);
    localparam logic [CHW-1:0]       LAST_CHAN = CHW'(N_CHAN - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_STAGGER,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CHW-1:0]       chan;      // next channel to be released in STAGGER
    logic [N_CHAN-1:0]    rst_q;
    logic                 running_q;
    logic                 done_q;
    logic [CNT_WIDTH-1:0] cycle_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_restart) begin
            state     <= S_HOLD;
            cnt       <= '0;
            chan      <= '0;
            rst_q     <= '1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cycle_q   <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (ALL_AT_ONCE) begin
                            rst_q     <= '0;
                            running_q <= 1'b1;
                            cycle_q   <= '0;
                            state     <= S_RUN;
                        end else begin
                            rst_q[0] <= 1'b0;
                            chan     <= CHW'(1);
                            state    <= S_STAGGER;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STAGGER: begin
                    if (cnt == STAG_LAST) begin
                        cnt   <= '0;
                        // mask-clear keeps already released bits low
                        rst_q <= rst_q & ~(N_CHAN'(1) << chan);
                        if (chan == LAST_CHAN) begin
                            running_q <= 1'b1;
                            cycle_q   <= '0;
                            state     <= S_RUN;
                        end else begin
                            chan <= chan + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if ((RUN_CYCLES != 0) && (cycle_q == RUN_LAST)) begin
                        rst_q     <= '1;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        cycle_q   <= '0;
                        state     <= S_DONE;
                    end else begin
                        cycle_q <= cycle_q + 1'b1;
                    end
                end
                default: begin
                    // DONE: parked until reset or restart
                    rst_q     <= '1;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                    cycle_q   <= '0;
                end
            endcase
        end
    end

    assign bus.o_rst     = rst_q;
    assign bus.o_running = running_q;
    assign bus.o_done    = done_q;
    assign bus.o_cycle   = cycle_q;
endmodule
